// File: rtl/bv8_inv_pipe.sv
// bv8_inv_pipe: 3-stage GF(2^8) inverter on the normal-basis tower GF(((2^2)^2)^2); BV8_INV_PIPE_ZERO_FLAG_EN adds out_zero.
// Latency 3 cycles, sustained throughput 1 byte/cycle.
// Backpressure: a full stage freezes while its successor stalls; bubbles collapse forward and out_ready = stage-1 advance.

package bv8_inv_pkg;

    // GF(2^2) in normal basis {W^2, W}: bit 1 = W^2 coefficient, bit 0 = W coefficient.
    function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [1:0] gf2_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    // Scale by N = W^2.
    function automatic logic [1:0] gf2_scl_n(input logic [1:0] x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    // Scale by N^2 = W.
    function automatic logic [1:0] gf2_scl_n2(input logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

    // nu * x^2 in GF(2^4), nu being the norm of the GF(2^8)/GF(2^4) basis element.
    function automatic logic [3:0] bv4_sq_scl(input logic [3:0] x);
        return {gf2_sq(x[3:2] ^ x[1:0]), gf2_scl_n2(gf2_sq(x[1:0]))};
    endfunction

    // GF(2^4) inverse; the GF(2^2) inverse is a bit swap, so 0 maps to 0 naturally.
    function automatic logic [3:0] bv4_inv(input logic [3:0] x);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] e;
        a = x[3:2];
        b = x[1:0];
        e = gf2_sq(gf2_scl_n(gf2_sq(a ^ b)) ^ gf2_mul(a, b));
        return {gf2_mul(e, b), gf2_mul(e, a)};
    endfunction

endpackage

// bv4_mul: GF(2^4) normal-basis multiplier, purely combinational.
module bv4_mul
    import bv8_inv_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] p_o
);

    logic [1:0] e;

    assign e   = gf2_scl_n(gf2_mul(a_i[3:2] ^ a_i[1:0], b_i[3:2] ^ b_i[1:0]));
    assign p_o = {gf2_mul(a_i[3:2], b_i[3:2]) ^ e, gf2_mul(a_i[1:0], b_i[1:0]) ^ e};

endmodule

module bv8_inv_pipe
    import bv8_inv_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [7:0]       in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             in_ready,
    output logic [7:0]       out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    logic             v1_q, v2_q, v3_q;
    logic             adv1, adv2, adv3;

    logic [3:0]       s1_ah_q, s1_al_q, s1_d_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [3:0]       s2_ah_q, s2_al_q, s2_dinv_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [7:0]       s3_dat_q;
    logic [TAG_W-1:0] s3_tag_q;

    logic [3:0]       ahl_prod;
    logic [3:0]       s1_d_d;
    logic [3:0]       s2_dinv_d;
    logic [3:0]       s3_hi_d, s3_lo_d;

    assign adv3 = in_ready | ~v3_q;
    assign adv2 = adv3 | ~v2_q;
    assign adv1 = adv2 | ~v1_q;

    assign out_ready = adv1;
    assign out_valid = v3_q;
    assign out_data  = s3_dat_q;
    assign out_tag   = s3_tag_q;

    bv4_mul u_mul_s1 (
        .a_i (in_data[7:4]),
        .b_i (in_data[3:0]),
        .p_o (ahl_prod)
    );

    assign s1_d_d    = ahl_prod ^ bv4_sq_scl(in_data[7:4] ^ in_data[3:0]);
    assign s2_dinv_d = bv4_inv(s1_d_q);

    // High output nibble pairs with al and low with ah: the normal basis swaps roles on inversion.
    bv4_mul u_mul_hi (
        .a_i (s2_al_q),
        .b_i (s2_dinv_q),
        .p_o (s3_hi_d)
    );

    bv4_mul u_mul_lo (
        .a_i (s2_ah_q),
        .b_i (s2_dinv_q),
        .p_o (s3_lo_d)
    );

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (adv1) v1_q <= in_valid;
            if (adv2) v2_q <= v1_q;
            if (adv3) v3_q <= v2_q;
        end
    end

    // Data registers load only with a real byte, so bubbles never disturb held values.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            s1_ah_q  <= '0;
            s1_al_q  <= '0;
            s1_d_q   <= '0;
            s1_tag_q <= '0;
        end else if (adv1 && in_valid) begin
            s1_ah_q  <= in_data[7:4];
            s1_al_q  <= in_data[3:0];
            s1_d_q   <= s1_d_d;
            s1_tag_q <= in_tag;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            s2_ah_q   <= '0;
            s2_al_q   <= '0;
            s2_dinv_q <= '0;
            s2_tag_q  <= '0;
        end else if (adv2 && v1_q) begin
            s2_ah_q   <= s1_ah_q;
            s2_al_q   <= s1_al_q;
            s2_dinv_q <= s2_dinv_d;
            s2_tag_q  <= s1_tag_q;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            s3_dat_q <= '0;
            s3_tag_q <= '0;
        end else if (adv3 && v2_q) begin
            s3_dat_q <= {s3_hi_d, s3_lo_d};
            s3_tag_q <= s2_tag_q;
        end
    end

`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
    logic z1_q, z2_q, z3_q;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            z1_q <= 1'b0;
            z2_q <= 1'b0;
            z3_q <= 1'b0;
        end else begin
            if (adv1 && in_valid) z1_q <= (in_data == 8'h00);
            if (adv2 && v1_q)     z2_q <= z1_q;
            if (adv3 && v2_q)     z3_q <= z2_q;
        end
    end

    assign out_zero = z3_q;
`endif

endmodule

// File: tb/tb_bv8_inv_pipe.sv
// tb_bv8_inv_pipe: scoreboard bench for bv8_inv_pipe (TAG_W = 8).
// Expected inverses come from a brute-force search over an independent tower-field multiplier.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.

module tb_bv8_inv_pipe;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] dout;
        logic [7:0] tag;
    } sb_t;

    logic       in_clock;
    logic       in_reset_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic [7:0] in_tag;
    logic       out_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [7:0] out_tag;
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int         checks;
    int         errors;
    sb_t        sbq[$];
    logic [7:0] inv_tab [256];

    logic       s_acc, s_emi, s_vld, s_rdy, s_zero;
    logic [7:0] s_dat, s_tag;

    bv8_inv_pipe #(.TAG_W(8)) dut (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_tag    (out_tag)
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    // GF(2^2): (a W^2 + b W)(c W^2 + d W) expanded with W^2 = W + 1.
    function automatic logic [1:0] m2(input logic [1:0] x, input logic [1:0] y);
        logic a, b, c, d;
        a = x[1]; b = x[0]; c = y[1]; d = y[0];
        return {(a & d) ^ (b & c) ^ (b & d), (a & c) ^ (a & d) ^ (b & c)};
    endfunction

    function automatic logic [3:0] m4(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] e;
        e = m2(2'b10, m2(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {m2(x[3:2], y[3:2]) ^ e, m2(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic logic [7:0] m8(input logic [7:0] x, input logic [7:0] y);
        logic [3:0] e;
        e = m4(4'h1, m4(x[7:4] ^ x[3:0], y[7:4] ^ y[3:0]));
        return {m4(x[7:4], y[7:4]) ^ e, m4(x[3:0], y[3:0]) ^ e};
    endfunction

    // One clock cycle: sample at the falling edge, log accepted stimulus, return just after the rising edge.
    task automatic tick();
        sb_t e;
        @(negedge in_clock);
        s_vld = out_valid;
        s_rdy = out_ready;
        s_dat = out_data;
        s_tag = out_tag;
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
        s_zero = out_zero;
`else
        s_zero = 1'b0;
`endif
        s_acc = in_valid && out_ready;
        s_emi = out_valid && in_ready;
        if (s_acc) begin
            e.din  = in_data;
            e.dout = inv_tab[in_data];
            e.tag  = in_tag;
            sbq.push_back(e);
        end
        @(posedge in_clock);
        #1;
    endtask

    task automatic test_reset();
        in_reset_n = 1'b0;
        in_valid   = 1'b0;
        in_ready   = 1'b1;
        in_data    = 8'h00;
        in_tag     = 8'h00;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: valid=%b data=%h tag=%h, want 0/00/00", out_valid, out_data, out_tag);
        end
        repeat (2) @(posedge in_clock);
        #1 in_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (s_vld !== 1'b0 || s_dat !== 8'h00 || s_rdy !== 1'b1) begin
                errors++;
                $display("FAIL idle_cycle%0d: valid=%b data=%h ready=%b, want 0/00/1", i, s_vld, s_dat, s_rdy);
            end
        end
        in_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h53;
        in_tag   = 8'h01;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL held_valid: out_valid=%b, want 1", out_valid);
        end
        #2 in_reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h, want 0/00", out_valid, out_data);
        end
        sbq.delete();
        @(posedge in_clock);
        #1 in_reset_n = 1'b1;
        in_ready = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        in_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_tag   = 8'h05;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (s_vld) lat = i;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, want 3", lat);
        end
        checks++;
        if (s_dat !== 8'hFF || s_tag !== 8'h05 || s_zero !== 1'b0) begin
            errors++;
            $display("FAIL single_result: data=%h tag=%h zero=%b, want FF/05/0", s_dat, s_tag, s_zero);
        end
        sbq.delete();
    endtask

    task automatic test_exhaustive();
        int  n, got, cyc;
        sb_t e;
        n = 0; got = 0; cyc = 0;
        in_ready = 1'b1;
        while (got < 256 && cyc < 1000) begin
            in_valid = (n < 256);
            in_data  = 8'(n);
            in_tag   = 8'(n);
            tick();
            if (s_acc) n++;
            if (s_emi) begin
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL exh_extra: unexpected output %h", s_dat);
                end else begin
                    e = sbq.pop_front();
                    if (s_dat !== e.dout || s_tag !== e.tag) begin
                        errors++;
                        $display("FAIL exh_data in=%h: data=%h tag=%h, want %h/%h", e.din, s_dat, s_tag, e.dout, e.tag);
                    end
                    checks++;
                    if (e.din != 8'h00 && m8(s_dat, e.din) !== 8'hFF) begin
                        errors++;
                        $display("FAIL exh_product in=%h: out*in=%h, want FF", e.din, m8(s_dat, e.din));
                    end else if (e.din == 8'h00 && s_dat !== 8'h00) begin
                        errors++;
                        $display("FAIL exh_zero: data=%h, want 00", s_dat);
                    end
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
                    checks++;
                    if (s_zero !== (e.din == 8'h00)) begin
                        errors++;
                        $display("FAIL exh_zflag in=%h: zero=%b", e.din, s_zero);
                    end
`endif
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 256 || cyc != 259) begin
            errors++;
            $display("FAIL exh_throughput: %0d results in %0d cycles, want 256 in 259", got, cyc);
        end
    endtask

    task automatic test_backpressure();
        int         n, got;
        logic       stall_prev;
        logic [7:0] dat_prev, tag_prev;
        sb_t        e;
        n = 0; got = 0;
        stall_prev = 1'b0;
        dat_prev = 8'h00;
        tag_prev = 8'h00;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_ready = !(cyc >= 5 && cyc <= 12);
            in_valid = (n < 10);
            in_data  = 8'(n + 1);
            in_tag   = 8'(8'h80 + n);
            tick();
            if (s_acc) n++;
            if (cyc == 12) begin
                checks++;
                if (s_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full_ready: out_ready=%b, want 0", s_rdy);
                end
            end
            if (stall_prev) begin
                checks++;
                if (s_dat !== dat_prev || s_tag !== tag_prev) begin
                    errors++;
                    $display("FAIL bp_stable cyc%0d: data=%h tag=%h, held %h/%h", cyc, s_dat, s_tag, dat_prev, tag_prev);
                end
            end
            stall_prev = s_vld && !in_ready;
            dat_prev   = s_dat;
            tag_prev   = s_tag;
            if (s_emi) begin
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected output %h tag %h", s_dat, s_tag);
                end else begin
                    e = sbq.pop_front();
                    if (s_dat !== e.dout || s_tag !== e.tag) begin
                        errors++;
                        $display("FAIL bp_order: data=%h tag=%h, want %h/%h", s_dat, s_tag, e.dout, e.tag);
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        checks++;
        if (got != 10 || sbq.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d results, %0d pending, want 10/0", got, sbq.size());
        end
    endtask

    task automatic test_random();
        int  sent, got, cyc, viol;
        sb_t e;
        sent = 0; got = 0; cyc = 0; viol = 0;
        while (got < 10000 && cyc < 60000) begin
            in_valid = (sent < 10000) && ($urandom_range(0, 1) == 1);
            in_ready = ($urandom_range(0, 1) == 1);
            in_data  = 8'($urandom);
            in_tag   = 8'(sent);
            tick();
            if (s_acc) sent++;
            if (in_ready && !s_rdy) viol++;
            if (s_emi) begin
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: unexpected output %h tag %h", s_dat, s_tag);
                end else begin
                    e = sbq.pop_front();
                    if (s_dat !== e.dout || s_tag !== e.tag || s_zero !== ((e.din == 8'h00) && s_zero)) begin
                        errors++;
                        $display("FAIL rnd_result in=%h: data=%h tag=%h, want %h/%h", e.din, s_dat, s_tag, e.dout, e.tag);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (got != 10000 || viol != 0) begin
            errors++;
            $display("FAIL rnd_summary: results=%0d ready_violations=%0d, want 10000/0", got, viol);
        end
        sent = 0; got = 0; cyc = 0;
        in_ready = 1'b1;
        while (got < 64 && cyc < 200) begin
            in_valid = (sent < 64);
            in_data  = 8'($urandom);
            in_tag   = 8'(sent);
            tick();
            if (s_acc) sent++;
            if (s_emi) begin
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL burst_extra: unexpected output %h", s_dat);
                end else begin
                    e = sbq.pop_front();
                    if (s_dat !== e.dout || s_tag !== e.tag) begin
                        errors++;
                        $display("FAIL burst_result: data=%h tag=%h, want %h/%h", s_dat, s_tag, e.dout, e.tag);
                    end
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 64 || cyc != 67) begin
            errors++;
            $display("FAIL burst_throughput: %0d results in %0d cycles, want 64 in 67", got, cyc);
        end
    endtask

    task automatic test_reset_inflight();
        int lat;
        in_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h10 + i);
            in_tag  = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        #2 in_reset_n = 1'b0;
        @(posedge in_clock);
        #1 in_reset_n = 1'b1;
        sbq.delete();
        in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_vld !== 1'b0) begin
                errors++;
                $display("FAIL inflight_drop cyc%0d: out_valid=%b, want 0", i, s_vld);
            end
        end
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_tag   = 8'h77;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (s_vld) lat = i;
        end
        checks++;
        if (lat != 3 || s_dat !== 8'h00 || s_tag !== 8'h77) begin
            errors++;
            $display("FAIL post_reset_byte: latency=%0d data=%h tag=%h, want 3/00/77", lat, s_dat, s_tag);
        end
`ifdef BV8_INV_PIPE_ZERO_FLAG_EN
        checks++;
        if (s_zero !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_zflag: zero=%b, want 1", s_zero);
        end
`endif
        sbq.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        inv_tab[0] = 8'h00;
        for (int x = 1; x < 256; x++) begin
            inv_tab[x] = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m8(8'(x), 8'(y)) == 8'hFF) inv_tab[x] = 8'(y);
        end
        test_reset();
        test_single();
        test_exhaustive();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bv8_inv_pipe.md
Name: bv8_inv_pipe

Overview:
- Three-stage pipelined GF(2^8) inverter built on the team's normal-basis tower field (GF(2^8) over GF(2^4) over GF(2^2)).
- Sits inside the S-box datapath, between the input linear map and the output linear map.
- Hosts the bv4_mul instances: stage 1 produces the GF(2^4) operand d, stage 2 inverts d, stage 3 performs the two bv4 multiplications.
- Unmasked. Valid/ready handshake on both sides; full throughput of 1 byte per cycle.

Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each byte (1..16).

Ports:
- in_clock  input  1  clock, rising edge.
- in_reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte valid.
- out_ready  output  1  block can accept a byte this cycle.
- in_data  input  8  bv8_t operand; [7:4] = ah (Y^16 coefficient), [3:0] = al (Y coefficient).
- in_tag  input  TAG_W  sideband tag, returned unchanged with its result.
- out_valid  output  1  result valid.
- in_ready  input  1  downstream accepts the result.
- out_data  output  8  inverse of the accepted in_data, same encoding.
- out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert): all stage valid bits = 0; out_valid = 0; out_data = 0; out_tag = 0; pipeline data registers = 0.
- Reset mid-operation drops all in-flight bytes; no partial results are emitted.
- Pipeline stages; each has a register slot and a valid bit v1/v2/v3:
  - S1 register: ah, al, tag, d = (ah ⊗ al) ⊕ sq_scl(ah ⊕ al). ⊗ is bv4_mul; sq_scl is the codebase's bv4 square-and-scale by nu.
  - S2 register: ah, al, tag, dinv = inv4(d). inv4 maps 0 to 0.
  - S3 register (output): out_data[7:4] = al ⊗ dinv, out_data[3:0] = ah ⊗ dinv, out_tag = tag.
- Encoding: field one is 8'hFF. Zero input maps to 8'h00 through the d = 0 path; no special case is needed.
- Stage advance rule: stage k loads when stage k is empty or stage k+1 loads this cycle (stage 4 means the downstream accepts).
  - adv3 = in_ready | ~v3
  - adv2 = adv3 | ~v2
  - adv1 = adv2 | ~v1
- Handshake:
  - out_ready = adv1. It depends combinationally on in_ready; no loop back to in_valid is permitted.
  - out_valid = v3.
  - Transfer on in_valid & out_ready, and on out_valid & in_ready.
- Latency: a byte accepted at cycle t appears with out_valid = 1 at cycle t+3 when no stall occurs.
- Stalls:
  - in_ready = 0 freezes every full stage and its data; bubbles collapse forward.
  - Registers hold their values when not loading; no data register changes on a non-advancing stage.
- Full: with v1 = v2 = v3 = 1 and in_ready = 0, out_ready = 0.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 byte/cycle indefinitely.
- out_data and out_tag must remain stable while out_valid = 1 and in_ready = 0.
- in_data and in_tag are sampled only on an accepted transfer; values while in_valid = 0 are don't-care.
- Ordering is strict FIFO; no reordering and no drops.

Optional Feature:
- Macro: BV8_INV_PIPE_ZERO_FLAG_EN.
- When defined:
  - Adds output port out_zero (1 bit): 1 iff the accepted in_data was 8'h00.
  - The flag is computed in S1 and piped through S2 and S3 alongside the tag.
  - Reset value 0; it obeys the same hold/stall rules as out_data.
- When undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: out_valid = 0, out_data = 8'h00, out_ready = 1 for 10 cycles; assert in_reset_n = 0 asynchronously mid-cycle → out_valid drops immediately.
- Single byte in_data = 8'hFF, tag = 4'h5 at cycle 0, in_ready = 1 → out_valid rises exactly at cycle 3 with out_data = 8'hFF and out_tag = 4'h5. With ZERO_FLAG, out_zero = 0.
- Exhaustive stream of all 256 values back-to-back, in_ready = 1 → one result per cycle in order. out_data ⊗8 in_data = 8'hFF for every nonzero value (golden bv8 multiplier model); input 8'h00 gives 8'h00 (and out_zero = 1 with ZERO_FLAG).
- Backpressure: stream 8'h01..8'h0A, hold in_ready = 0 from cycle 5 to cycle 12 → out_ready = 0 once 3 bytes are held. out_data/out_tag stable while stalled; all 10 results arrive in order with no loss or duplication after in_ready returns to 1.
- Random in_valid/in_ready at 50% each, 10k bytes, TAG_W = 8 carrying a sequence number → scoreboard matches every result and tag; throughput reaches 1/cycle whenever both are held high.
- Reset with 3 bytes in flight → after release out_valid stays 0 until a new byte is accepted; that byte's result appears 3 cycles later.
